// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hold/bubble controller for the 5-stage core.
// Freezes the PC and pipeline registers and injects bubbles for load-use
// hazards, instruction-memory misses, multi-cycle data accesses and halt.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   ID_rs/ID_rt(+valid)- source registers read by the instruction in ID
//   EX_memRead/EX_regWrite/EX_writereg - load/destination info of EX instr
//   branch_or_jmp      - redirect this cycle
//   imem_stall         - fetch not ready
//   dmem_stall/done    - data access start / completion
//   WB_halt            - halt instruction reached WB
//   *_hold, *_bubble   - enables for PC and the four pipeline registers
//   state              - RUN=00, LU=01, MEMW=10, HALT=11
//   halted             - in HALT
//   dmem_timeout       - sticky: data access waited MEMW_TIMEOUT cycles
//   stall_cycles       - saturating count of cycles with pc_hold=1
module stall_ctrl #(
   parameter int MEMW_TIMEOUT = 255,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       ID_rs,
   input  logic [2:0]       ID_rt,
   input  logic             ID_rs_valid,
   input  logic             ID_rt_valid,
   input  logic             EX_memRead,
   input  logic             EX_regWrite,
   input  logic [2:0]       EX_writereg,
   input  logic             branch_or_jmp,
   input  logic             imem_stall,
   input  logic             dmem_stall,
   input  logic             dmem_done,
   input  logic             WB_halt,
   output logic             pc_hold,
   output logic             IF_ID_hold,
   output logic             IF_ID_bubble,
   output logic             ID_EX_hold,
   output logic             ID_EX_bubble,
   output logic             EX_MEM_hold,
   output logic             MEM_WB_bubble,
   output logic [1:0]       state,
   output logic             halted,
   output logic             dmem_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      LU   = 2'b01,
      MEMW = 2'b10,
      HALT = 2'b11
   } state_t;

   localparam logic [7:0]       TMO     = 8'(MEMW_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           cur, nxt;
   logic [7:0]       wait_cnt;
   logic             timeout_q;
   logic [CNT_W-1:0] stall_cnt;
   logic             load_use;
   logic             pc_h, ifid_h, ifid_b, idex_h, idex_b, exmem_h, memwb_b;

   // A redirect squashes the ID instruction, so no load-use stall is needed.
   assign load_use = EX_memRead & EX_regWrite & ~branch_or_jmp &
                     ((ID_rs_valid & (ID_rs == EX_writereg)) |
                      (ID_rt_valid & (ID_rt == EX_writereg)));

   always_comb begin
      nxt     = cur;
      pc_h    = 1'b0;
      ifid_h  = 1'b0;
      ifid_b  = 1'b0;
      idex_h  = 1'b0;
      idex_b  = 1'b0;
      exmem_h = 1'b0;
      memwb_b = 1'b0;
      case (cur)
         RUN: begin
            if (WB_halt) begin
               pc_h = 1'b1; ifid_h = 1'b1; idex_h = 1'b1; exmem_h = 1'b1;
               nxt  = HALT;
            end else if (dmem_stall) begin
               // A done in the same cycle is still treated as a new stall.
               pc_h = 1'b1; ifid_h = 1'b1; idex_h = 1'b1; exmem_h = 1'b1;
               memwb_b = 1'b1;
               nxt  = MEMW;
            end else if (load_use) begin
               pc_h = 1'b1; ifid_h = 1'b1; idex_b = 1'b1;
               nxt  = LU;
            end else if (imem_stall) begin
               // On a redirect the PC must take the branch target.
               pc_h   = ~branch_or_jmp;
               ifid_b = 1'b1;
            end
         end
         // Bubble is already in EX; hazard is not re-evaluated.
         LU: nxt = RUN;
         MEMW: begin
            if (dmem_done) begin
               nxt = RUN;
            end else begin
               // Branch stays held in EX and re-asserts after release.
               pc_h = 1'b1; ifid_h = 1'b1; idex_h = 1'b1; exmem_h = 1'b1;
               memwb_b = 1'b1;
            end
         end
         HALT: begin
            pc_h = 1'b1; ifid_h = 1'b1; idex_h = 1'b1; exmem_h = 1'b1;
         end
         default: nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur       <= RUN;
         wait_cnt  <= 8'd0;
         timeout_q <= 1'b0;
         stall_cnt <= '0;
      end else begin
         cur <= nxt;
         if (cur != MEMW && nxt == MEMW) begin
            wait_cnt <= 8'd0;
         end else if (cur == MEMW && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == TMO) timeout_q <= 1'b1;
         end
         if (pc_h && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   // Every output is forced low while reset is asserted.
   assign pc_hold       = pc_h    & ~rst;
   assign IF_ID_hold    = ifid_h  & ~rst;
   assign IF_ID_bubble  = ifid_b  & ~rst;
   assign ID_EX_hold    = idex_h  & ~rst;
   assign ID_EX_bubble  = idex_b  & ~rst;
   assign EX_MEM_hold   = exmem_h & ~rst;
   assign MEM_WB_bubble = memwb_b & ~rst;
   assign state         = rst ? 2'b00 : cur;
   assign halted        = (cur == HALT) & ~rst;
   assign dmem_timeout  = timeout_q & ~rst;
   assign stall_cycles  = rst ? '0 : stall_cnt;

endmodule
